// File: rtl/pixel_row_serializer_if.sv
// Pixel stream handshake between the row serializer and its consumer.
interface pixel_row_serializer_if;
    logic pix_out;
    logic pix_valid;
    logic pix_ready;
    logic pix_last;

    modport master (output pix_out, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_out, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/pixel_row_serializer.sv
// Reads a row of double-width words from RAM and emits them one pixel bit per
// transfer, MSB first, over a valid/ready stream with a last-pixel marker.
module pixel_row_serializer #(
    parameter int address_width = 10,
    parameter int data_width    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [address_width-1:0]   start_address,
    input  logic [7:0]                 word_count,
    output logic [address_width-1:0]   ram_address,
    input  logic [2*data_width-1:0]    ram_q,
    pixel_row_serializer_if.master     pix,
    output logic                       busy,
    output logic                       done
);

    localparam int WORD_W = 2 * data_width;
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0]         BITS_FULL = BIT_W'(WORD_W);
    localparam logic [BIT_W-1:0]         BITS_ONE  = BIT_W'(1);
    localparam logic [address_width-1:0] ADDR_STEP = address_width'(2);
    // Read latency: one edge into ram_address, one edge through the RAM.
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state, state_nxt;
    logic [WORD_W-1:0]    shift_q, pf_q;
    logic                 shift_vld, pf_vld;
    logic [BIT_W-1:0]     bits_left;
    logic [8:0]           total, fetch_cnt, words_left;
    logic [STAGES:0]      vld_pipe;

    logic                 xfer, word_done, last_xfer, capture, issue, shift_free;
    logic [2:0]           occ;

    assign xfer       = shift_vld & pix.pix_ready;
    assign word_done  = xfer && (bits_left == BITS_ONE);
    assign last_xfer  = word_done && (words_left == 9'd1);
    assign capture    = vld_pipe[STAGES];
    assign shift_free = !shift_vld || word_done;

    // Words held plus words in flight; never allowed past the two word slots.
    always_comb begin
        occ = 3'(shift_vld) + 3'(pf_vld);
        for (int i = 0; i <= STAGES; i++) occ = occ + 3'(vld_pipe[i]);
    end

    assign pix.pix_valid = shift_vld;
    assign pix.pix_out   = shift_q[WORD_W-1];
    assign pix.pix_last  = shift_vld && (bits_left == BITS_ONE) && (words_left == 9'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != 8'd0) begin
                        state_nxt = RUN;
                        issue     = 1'b1;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (fetch_cnt != total && (occ - 3'(word_done)) < 3'd2) issue = 1'b1;
                if (last_xfer) state_nxt = FINISH;
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe    <= '0;
            ram_address <= '0;
            fetch_cnt   <= '0;
            total       <= '0;
            words_left  <= '0;
            shift_q     <= '0;
            shift_vld   <= 1'b0;
            bits_left   <= '0;
            pf_q        <= '0;
            pf_vld      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};

            if (issue) begin
                if (state == IDLE) begin
                    ram_address <= start_address;
                    fetch_cnt   <= 9'd1;
                end else begin
                    ram_address <= ram_address + ADDR_STEP;
                    fetch_cnt   <= fetch_cnt + 9'd1;
                end
            end

            if (state == IDLE && start) begin
                total      <= {1'b0, word_count};
                words_left <= {1'b0, word_count};
            end else if (word_done) begin
                words_left <= words_left - 9'd1;
            end

            // Refill the shift register on the edge its last bit leaves, so
            // consecutive words stream without a bubble.
            if (shift_free) begin
                if (pf_vld) begin
                    shift_q   <= pf_q;
                    shift_vld <= 1'b1;
                    bits_left <= BITS_FULL;
                    pf_vld    <= capture;
                    if (capture) pf_q <= ram_q;
                end else if (capture) begin
                    shift_q   <= ram_q;
                    shift_vld <= 1'b1;
                    bits_left <= BITS_FULL;
                end else begin
                    shift_q   <= '0;
                    shift_vld <= 1'b0;
                    bits_left <= '0;
                end
            end else begin
                if (xfer) begin
                    shift_q   <= {shift_q[WORD_W-2:0], 1'b0};
                    bits_left <= bits_left - BITS_ONE;
                end
                if (capture) begin
                    pf_q   <= ram_q;
                    pf_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Scoreboard bench: rows are expanded into expected pixels from RAM contents,
// and a monitor compares every accepted pixel against that queue.
module tb_pixel_row_serializer;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int WB = 2 * DW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [7:0]    word_count = '0;
    logic [AW-1:0] ram_address;
    logic [AW-1:0] ram_nxt;
    logic [WB-1:0] ram_q = '0;
    logic          busy, done;
    logic [7:0]    mem [0:DEPTH-1];

    pixel_row_serializer_if pix();

    pixel_row_serializer #(.address_width(AW), .data_width(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_address(start_address), .word_count(word_count),
        .ram_address(ram_address), .ram_q(ram_q), .pix(pix),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign ram_nxt = ram_address + AW'(1);
    always @(posedge clk) ram_q <= {mem[ram_address], mem[ram_nxt]};

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    logic [1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: word i lives at (sa + 2i) mod DEPTH, emitted MSB first.
    task automatic push_row(input int sa, input int wc);
        int a, b;
        logic [WB-1:0] w;
        for (int i = 0; i < wc; i++) begin
            a = (sa + 2 * i) % DEPTH;
            b = (a + 1) % DEPTH;
            w = {mem[a], mem[b]};
            for (int j = WB - 1; j >= 0; j--)
                exp_q.push_back({w[j], 1'(i == wc - 1 && j == 0)});
        end
    endtask

    task automatic monitor();
        logic prev_stall, prev_out, prev_last;
        logic [1:0] e;
        prev_stall = 1'b0; prev_out = 1'b0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(pix.pix_valid), 32'd1);
                chk("stall_out", 32'(pix.pix_out), 32'(prev_out));
                chk("stall_last", 32'(pix.pix_last), 32'(prev_last));
            end
            if (pix.pix_valid && pix.pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel: got pixel %0b with nothing expected", pix.pix_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_out", 32'(pix.pix_out), 32'(e[1]));
                    chk("pix_last", 32'(pix.pix_last), 32'(e[0]));
                end
                xfer_cnt++;
            end
            prev_stall = pix.pix_valid && !pix.pix_ready;
            prev_out   = pix.pix_out;
            prev_last  = pix.pix_last;
        end
    endtask

    // mode: 0 ready high, 1 ready toggling 1,0, 2 random ready.
    task automatic run_row(input int sa, input int wc, input int mode, input int abort_at, input bit pulse);
        int k, first_v, last_k, done_k, done_n, busy_n, vcnt, x0, budget;
        bit fin;
        logic [AW-1:0] a0, a1;
        k = 0; first_v = -1; last_k = -1; done_k = -1; done_n = 0; busy_n = 0; vcnt = 0;
        fin = 1'b0; a0 = '0; a1 = '0;
        budget = 64 * wc + 64;
        push_row(sa, wc);
        x0 = xfer_cnt;
        @(posedge clk); #1;
        start = 1'b1; start_address = AW'(sa); word_count = 8'(wc);
        @(posedge clk); #1;
        start = 1'b0; start_address = AW'($urandom); word_count = 8'($urandom);
        while (!fin && k < budget) begin
            case (mode)
                0: pix.pix_ready = 1'b1;
                1: pix.pix_ready = (k % 2 == 0);
                default: pix.pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (pulse && (k == 3 || k == 20)) begin
                start = 1'b1; start_address = AW'($urandom); word_count = 8'($urandom_range(1, 3));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0) a0 = ram_address;
            if (k == 1) a1 = ram_address;
            if (busy) busy_n++;
            if (done) begin done_n++; done_k = k; end
            if (pix.pix_valid) begin
                vcnt++;
                if (first_v < 0) first_v = k;
            end
            if (pix.pix_valid && pix.pix_ready && pix.pix_last) last_k = k;
            if (abort_at >= 0 && xfer_cnt - x0 >= abort_at) fin = 1'b1;
            if (!busy) fin = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: row at %0h still busy after %0d cycles, limit %0d", sa, k, budget);
        end
        if (abort_at >= 0) return;
        chk("done_pulses", 32'(done_n), 32'd1);
        chk("busy_cycles", 32'(busy_n), 32'(done_k + 1));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (wc == 0) begin
            chk("wc0_valid", 32'(vcnt), 32'd0);
            chk("wc0_done_k", 32'(done_k), 32'd0);
        end else begin
            chk("done_after_last", 32'(done_k), 32'(last_k + 1));
            chk("xfers", 32'(xfer_cnt - x0), 32'(WB * wc));
            chk("addr0", 32'(a0), 32'(sa % DEPTH));
            if (wc >= 2) chk("addr1", 32'(a1), 32'((sa + 2) % DEPTH));
            if (mode == 0) begin
                chk("first_valid", 32'(first_v), 32'd2);
                chk("valid_cycles", 32'(vcnt), 32'(WB * wc));
                chk("last_cycle", 32'(last_k), 32'(WB * wc + 1));
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix.pix_valid), 32'd0);
        chk({tag, "_pix_out"}, 32'(pix.pix_out), 32'd0);
        chk({tag, "_pix_last"}, 32'(pix.pix_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        mem[16'h10] = 8'hA5; mem[16'h11] = 8'h3C; mem[16'h12] = 8'hFF; mem[16'h13] = 8'h00;
        pix.pix_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;

        run_row(16'h10, 2, 0, -1, 1'b0);
        run_row(16'h10, 2, 1, -1, 1'b0);
        run_row(16'h40, 0, 0, -1, 1'b0);
        run_row(16'h3FE, 2, 0, -1, 1'b0);

        run_row(16'h100, 3, 0, 7, 1'b0);
        reset_n = 1'b0;
        #1;
        check_quiet("abort");
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_row(16'h20, 3, 0, -1, 1'b0);

        for (int r = 0; r < 10; r++)
            run_row(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 5)),
                    int'($urandom_range(0, 2)), -1, 1'b0);

        run_row(int'($urandom_range(0, DEPTH - 1)), 255, 0, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_row_serializer.md
PIXEL_ROW_SERIALIZER -- requirements
Module: pixel_row_serializer

Interface
REQ-001 Parameter address_width, default 10, SHALL set the RAM byte-address width.
REQ-002 Parameter data_width, default 8, SHALL set the RAM byte width; one fetched word is 2*data_width bits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a row when sampled high while idle.
REQ-006 start_address  input  address_width  SHALL give the byte address of the first word.
REQ-007 word_count  input  8  SHALL give the number of words in the row.
REQ-008 ram_address  output  address_width  SHALL be a registered read address to the double-width RAM read port.
REQ-009 ram_q  input  2*data_width  SHALL carry {mem[a], mem[a+1]} one edge after the RAM samples a.
REQ-010 pix_out  output  1  SHALL carry the current pixel bit.
REQ-011 pix_valid  output  1  SHALL indicate pix_out is valid.
REQ-012 pix_ready  input  1  SHALL indicate the consumer accepts pix_out this cycle.
REQ-013 pix_last  output  1  SHALL mark the final pixel of the row, qualified by pix_valid.
REQ-014 busy  output  1  SHALL be high from start acceptance until done.
REQ-015 done  output  1  SHALL pulse high for one cycle when a row completes.

Function
REQ-016 States SHALL be IDLE, RUN, FINISH; IDLE->RUN on start with word_count>0; IDLE->FINISH on start with word_count=0; RUN->FINISH when the last pixel transfers; FINISH->IDLE unconditionally after one cycle.
REQ-017 done SHALL be high exactly in FINISH; busy SHALL be high in RUN and FINISH.
REQ-018 start SHALL be ignored while busy.
REQ-019 Word i SHALL be read from start_address + 2*i, modulo 2^address_width (wrap-around silent).
REQ-020 ram_address SHALL load start_address on the edge that accepts start; ram_q for an address SHALL be captured on the second rising edge after ram_address takes that value.
REQ-021 The block SHALL hold one shift register and one prefetch word register; a fetch SHALL be issued whenever the prefetch register is empty or being emptied, and words remain unfetched.
REQ-022 Pixels SHALL be emitted MSB first: bit 2*data_width-1 of each word first, bit 0 last.
REQ-023 A pixel SHALL transfer when pix_valid and pix_ready are both high; pix_out, pix_valid and pix_last SHALL hold stable while pix_valid is high and pix_ready is low.
REQ-024 When a word's last bit transfers and the prefetch word is present, the next word SHALL load into the shift register on the same edge (no bubble).
REQ-025 With pix_ready held high, pix_valid SHALL first rise two cycles after the start-accept edge and stay high continuously until pix_last transfers.
REQ-026 pix_last SHALL be high only on bit 0 of word word_count-1.
REQ-027 Internal word counters SHALL be 9 bits so word_count=255 completes without overflow.
REQ-028 Fetched data arriving after the row's final needed word SHALL not be requested (exactly word_count fetches per row).

Reset
REQ-029 On reset_n low, asynchronously: state=IDLE, ram_address=0, pix_out=0, pix_valid=0, pix_last=0, busy=0, done=0, shift/prefetch registers and counters cleared.
REQ-030 Reset mid-row SHALL abandon the row with no done pulse; the first start after reset_n rises SHALL begin a fresh row.

Verification
REQ-031 data_width=8, RAM bytes 0x10..0x13 = A5,3C,FF,00; start_address=0x10, word_count=2, pix_ready=1 -> pix_valid high cycles 2..33, bits A53C then FF00 MSB first, pix_last on 32nd pixel, done one cycle later.
REQ-032 Same row, pix_ready toggling 1,0 -> identical 32-bit sequence, outputs stable in stalled cycles, exactly 32 transfers.
REQ-033 word_count=0 -> no fetch, pix_valid never high, busy and done high for exactly one cycle.
REQ-034 address_width=10, start_address=0x3FE, word_count=2 -> ram_address sequence 0x3FE, 0x000.
REQ-035 reset_n low at pixel 7 of a 3-word row -> all outputs 0 immediately, no done; new start_address=0x20 row runs correctly.
REQ-036 start pulsed again during RUN -> ignored; word_count=255 row emits 4080 pixels then done.
